// File: rtl/code_decoder_hs.sv
// Registered binary-to-one-hot decoder with valid/ready input and ack-terminated output.
// Optional ack timeout is enabled by defining DECODER_TIMEOUT_EN.
module code_decoder_hs #(
    parameter int CODE_W  = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CODE_W-1:0]    in_code,
    output logic                 in_ready,
    output logic [2**CODE_W-1:0] dec_out,
    output logic                 dec_valid,
    input  logic                 dec_ack,
    output logic [CNT_W-1:0]     txn_cnt,
    output logic                 timeout_err
);

    localparam int NLINES = 2**CODE_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [NLINES-1:0]   dec_out_q, dec_out_d;
    logic                dec_valid_q, dec_valid_d;
    logic [CNT_W-1:0]    txn_cnt_q, txn_cnt_d;
    logic                accept;

`ifdef DECODER_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    // A finishing line can be replaced in the same cycle it is acked.
    assign in_ready = (state_q == IDLE) | ((state_q == BUSY) & dec_ack);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        dec_out_d   = dec_out_q;
        dec_valid_d = dec_valid_q;
        txn_cnt_d   = txn_cnt_q;
`ifdef DECODER_TIMEOUT_EN
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
`endif
        if (accept) begin
            state_d     = BUSY;
            dec_out_d   = NLINES'(1) << in_code;
            dec_valid_d = 1'b1;
            txn_cnt_d   = txn_cnt_q + 1'b1;
`ifdef DECODER_TIMEOUT_EN
            timer_d     = '0;
`endif
        end else if (state_q == BUSY) begin
            if (dec_ack) begin
                state_d     = IDLE;
                dec_out_d   = '0;
                dec_valid_d = 1'b0;
            end
`ifdef DECODER_TIMEOUT_EN
            // Ack on the limit cycle takes the branch above, so no error then.
            else if (timer_q == TMR_W'(TIMEOUT)) begin
                state_d       = IDLE;
                dec_out_d     = '0;
                dec_valid_d   = 1'b0;
                timeout_err_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dec_out_q   <= '0;
            dec_valid_q <= 1'b0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            dec_out_q   <= dec_out_d;
            dec_valid_q <= dec_valid_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

`ifdef DECODER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign dec_out   = dec_out_q;
    assign dec_valid = dec_valid_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_code_decoder_hs.sv
// Scoreboard bench for code_decoder_hs: random and directed handshakes against a
// transaction-level model; honours DECODER_TIMEOUT_EN when the build defines it.
module tb_code_decoder_hs;

    localparam int CODE_W  = 2;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 15;
    localparam int NLINES  = 2**CODE_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [CODE_W-1:0] in_code = '0;
    logic              in_ready;
    logic [NLINES-1:0] dec_out;
    logic              dec_valid;
    logic              dec_ack = 1'b0;
    logic [CNT_W-1:0]  txn_cnt;
    logic              timeout_err;

    code_decoder_hs #(.CODE_W(CODE_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .dec_out(dec_out), .dec_valid(dec_valid),
        .dec_ack(dec_ack), .txn_cnt(txn_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct { int line; int cnt; } exp_t;
    exp_t sb[$];

    // Reference model: which line (if any) is owed service, and how many codes taken.
    bit busy_m = 0;
    int line_m = 0;
    int cnt_m  = 0;
    int wait_m = 0;
    bit terr_m = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any newly presented line must match the oldest outstanding accept.
    bit mon_en = 0;
    bit pv = 0;
    int po = 0, pc = 0;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("valid_matches_lines", int'(dec_valid), int'(|dec_out));
            chk("at_most_one_line", int'((dec_out & (dec_out - 1'b1)) != 0), 0);
            if (dec_valid && (!pv || int'(dec_out) != po || int'(txn_cnt) != pc)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_dec_out", int'(dec_out), 1 << e.line);
                    chk("sb_txn_cnt", int'(txn_cnt), e.cnt);
                end
            end
            pv = dec_valid;
            po = int'(dec_out);
            pc = int'(txn_cnt);
        end else begin
            pv = 0;
        end
    end

    // One clock of stimulus; entered and left at a negedge.
    task automatic cycle(input bit v, input int c, input bit a);
        bit rdy;
        in_valid = v;
        in_code  = CODE_W'(c);
        dec_ack  = a;
        #1;
        rdy = !busy_m || a;
        chk("in_ready", int'(in_ready), int'(rdy));
        @(posedge clk);
        terr_m = 0;
        if (v && rdy) begin
            busy_m = 1;
            line_m = c % NLINES;
            cnt_m  = (cnt_m + 1) % (1 << CNT_W);
            wait_m = 0;
            sb.push_back('{line: line_m, cnt: cnt_m});
        end else if (busy_m && a) begin
            busy_m = 0;
        end else if (busy_m) begin
`ifdef DECODER_TIMEOUT_EN
            if (wait_m == TIMEOUT) begin
                busy_m = 0;
                terr_m = 1;
            end else begin
                wait_m++;
            end
`endif
        end
        @(negedge clk);
        chk("dec_valid", int'(dec_valid), int'(busy_m));
        chk("dec_out", int'(dec_out), busy_m ? (1 << line_m) : 0);
        chk("txn_cnt", int'(txn_cnt), cnt_m);
        chk("timeout_err", int'(timeout_err), int'(terr_m));
    endtask

    int start_cnt;
    int hold;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_dec_out", int'(dec_out), 0);
        chk("reset_dec_valid", int'(dec_valid), 0);
        chk("reset_txn_cnt", int'(txn_cnt), 0);
        chk("reset_timeout_err", int'(timeout_err), 0);
        rst_n = 1'b1;
        mon_en = 1;
        @(negedge clk);

        // Single transaction on the top line, acked after three busy cycles.
        cycle(1, 3, 0);
        chk("single_line3", int'(dec_out), 8);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("single_cnt", int'(txn_cnt), 1);

        // Back-to-back: line 0 acked while code 2 is accepted.
        cycle(1, 0, 0);
        cycle(1, 2, 1);
        chk("b2b_line2", int'(dec_out), 4);
        chk("b2b_cnt", int'(txn_cnt), 3);
        cycle(0, 0, 1);

        // Ack in IDLE and toggling code without valid must do nothing.
        for (int i = 0; i < 6; i++) cycle(0, i, i % 2);
        chk("ignore_cnt", int'(txn_cnt), 3);
        chk("ignore_out", int'(dec_out), 0);

        // Reset mid-busy drops line 2 asynchronously.
        cycle(1, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dec_out", int'(dec_out), 0);
        chk("async_rst_dec_valid", int'(dec_valid), 0);
        chk("async_rst_txn_cnt", int'(txn_cnt), 0);
        busy_m = 0; cnt_m = 0; wait_m = 0; terr_m = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0);

        // 256 accepts wrap the counter back to its start; one more steps it.
        start_cnt = int'(txn_cnt);
        for (int i = 0; i < 256; i++) cycle(1, int'($urandom_range(0, NLINES - 1)), 1);
        chk("wrap_256", int'(txn_cnt), start_cnt);
        cycle(1, 1, 1);
        chk("wrap_257", int'(txn_cnt), (start_cnt + 1) % 256);
        cycle(0, 0, 1);

`ifdef DECODER_TIMEOUT_EN
        // Never acked: line 1 for TIMEOUT+1 cycles, then a one-cycle error pulse.
        cycle(1, 1, 0);
        hold = 1;
        for (int i = 0; i < 3 * TIMEOUT && dec_valid; i++) begin
            cycle(0, 0, 0);
            if (dec_valid) hold++;
        end
        chk("timeout_hold_cycles", hold, TIMEOUT + 1);
        chk("timeout_pulse", int'(timeout_err), 1);
        cycle(0, 0, 0);
        chk("timeout_pulse_one_cycle", int'(timeout_err), 0);
        // Ack arriving on the limit cycle wins.
        cycle(1, 1, 0);
        for (int i = 0; i < TIMEOUT; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("ack_at_limit_no_err", int'(timeout_err), 0);
`endif

        // Random traffic with varied ack density.
        for (int i = 0; i < 1500; i++) begin
            bit a;
            a = ($urandom_range(0, 99) < ((i / 300) % 2 ? 10 : 45));
            cycle(($urandom_range(0, 99) < 55), int'($urandom_range(0, NLINES - 1)), a);
        end
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
